// File: rtl/ws2812_frame_buffer.sv
// Ping-pong pixel frame buffer feeding a WS2812 driver: byte stream fills the back bank, frame_sync swaps.
// Optional build macro GRB_REORDER_EN stores each R,G,B triple as G,R,B.
module ws2812_frame_buffer #(
   parameter int unsigned FRAME_BYTES    = 183,
   parameter int unsigned ADDR_W         = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        in_byte,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   input  logic              frame_sync,
   output logic              frame_ready,
   output logic [ADDR_W-1:0] wr_count,
   output logic              timeout_pulse
);

   localparam int unsigned MEM_W   = $clog2(2 * FRAME_BYTES);
   localparam int unsigned IDLE_W  = 32;
   localparam int unsigned MEM_LEN = 2 * FRAME_BYTES;

   typedef enum logic {FILL, WAIT_SWAP} state_t;

   state_t              state, state_d;
   logic                front_sel, front_sel_d;
   logic                frame_ready_d;
   logic                in_ready_d;
   logic                timeout_pulse_d;
   logic [ADDR_W-1:0]   wr_count_d;
   logic [IDLE_W-1:0]   idle_cnt, idle_cnt_d;
   logic                xfer_c;
   logic                we_c;
   logic [ADDR_W-1:0]   waddr_c;
   logic [MEM_W-1:0]    wr_idx_c;
   logic [MEM_W-1:0]    rd_idx_c;

   logic [7:0] mem [MEM_LEN];

   assign xfer_c = in_valid && in_ready;

   // State and control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= FILL;
         front_sel     <= 1'b0;
         frame_ready   <= 1'b0;
         in_ready      <= 1'b0;
         timeout_pulse <= 1'b0;
         wr_count      <= '0;
         idle_cnt      <= '0;
      end else begin
         state         <= state_d;
         front_sel     <= front_sel_d;
         frame_ready   <= frame_ready_d;
         in_ready      <= in_ready_d;
         timeout_pulse <= timeout_pulse_d;
         wr_count      <= wr_count_d;
         idle_cnt      <= idle_cnt_d;
      end
   end

   // Writer FSM: fill back bank, idle timeout, swap on frame_sync once full
   always_comb begin
      state_d         = state;
      front_sel_d     = front_sel;
      frame_ready_d   = frame_ready;
      timeout_pulse_d = 1'b0;
      wr_count_d      = wr_count;
      idle_cnt_d      = idle_cnt;
      we_c            = 1'b0;
      case (state)
         FILL: begin
            if (xfer_c) begin
               we_c       = 1'b1;
               wr_count_d = wr_count + ADDR_W'(1);
               idle_cnt_d = '0;
               if (wr_count == ADDR_W'(FRAME_BYTES - 1)) begin
                  state_d = WAIT_SWAP;
               end
            end else if (wr_count != '0) begin
               if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                  wr_count_d      = '0;
                  idle_cnt_d      = '0;
                  timeout_pulse_d = 1'b1;
               end else begin
                  idle_cnt_d = idle_cnt + IDLE_W'(1);
               end
            end else begin
               idle_cnt_d = '0;
            end
         end
         WAIT_SWAP: begin
            if (frame_sync) begin
               front_sel_d   = ~front_sel;
               frame_ready_d = 1'b1;
               wr_count_d    = '0;
               idle_cnt_d    = '0;
               state_d       = FILL;
            end
         end
         default: state_d = FILL;
      endcase
      in_ready_d = (state_d == FILL);
   end

`ifdef GRB_REORDER_EN
   logic [1:0] phase;

   // Byte position within the current R,G,B triple
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= 2'd0;
      end else if (wr_count_d == '0) begin
         phase <= 2'd0;
      end else if (we_c) begin
         phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
      end
   end

   always_comb begin
      case (phase)
         2'd0:    waddr_c = wr_count + ADDR_W'(1);
         2'd1:    waddr_c = wr_count - ADDR_W'(1);
         default: waddr_c = wr_count;
      endcase
   end
`else
   assign waddr_c = wr_count;
`endif

   assign wr_idx_c = MEM_W'(waddr_c) + (front_sel ? MEM_W'(0) : MEM_W'(FRAME_BYTES));
   assign rd_idx_c = MEM_W'(rd_addr) + (front_sel ? MEM_W'(FRAME_BYTES) : MEM_W'(0));

   // Back-bank write port; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (we_c && (32'(waddr_c) < FRAME_BYTES)) begin
         mem[wr_idx_c] <= in_byte;
      end
   end

   // Front-bank read port; dark until a frame has been swapped in
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= 8'h00;
      end else if (frame_ready && (32'(rd_addr) < FRAME_BYTES)) begin
         rd_data <= mem[rd_idx_c];
      end else begin
         rd_data <= 8'h00;
      end
   end

endmodule

// File: tb/tb_ws2812_frame_buffer.sv
// Directed self-checking bench for ws2812_frame_buffer (default parameters, either GRB_REORDER_EN setting).
module tb_ws2812_frame_buffer;

`ifdef GRB_REORDER_EN
   localparam bit REORDER = 1'b1;
`else
   localparam bit REORDER = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_byte = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] rd_addr = 8'h00;
   logic [7:0] rd_data;
   logic       frame_sync = 1'b0;
   logic       frame_ready;
   logic [7:0] wr_count;
   logic       timeout_pulse;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] exp;
   } rd_vec_t;

   rd_vec_t tbl_a [9];

   ws2812_frame_buffer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_byte       (in_byte),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .frame_sync    (frame_sync),
      .frame_ready   (frame_ready),
      .wr_count      (wr_count),
      .timeout_pulse (timeout_pulse)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present one byte, wait (bounded) for in_ready, then let it transfer; in_valid stays high
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      in_byte  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 1000) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_byte: in_ready stuck at %0b expected 1", in_ready);
      end
      tick();
   endtask

   task automatic read_check(input string name, input logic [7:0] a, input logic [7:0] exp);
      rd_addr = a;
      tick();
      check(name, 32'(rd_data), 32'(exp));
   endtask

   task automatic pulse_sync();
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
   endtask

   initial begin
      int k_hit;
      int pulses;

      // Frame A holds value i at byte index i
      tbl_a[0] = '{8'd0,   REORDER ? 8'd1   : 8'd0};
      tbl_a[1] = '{8'd1,   REORDER ? 8'd0   : 8'd1};
      tbl_a[2] = '{8'd2,   8'd2};
      tbl_a[3] = '{8'd5,   8'd5};
      tbl_a[4] = '{8'd180, REORDER ? 8'd181 : 8'd180};
      tbl_a[5] = '{8'd181, REORDER ? 8'd180 : 8'd181};
      tbl_a[6] = '{8'd182, 8'd182};
      tbl_a[7] = '{8'd183, 8'h00};
      tbl_a[8] = '{8'd255, 8'h00};

      // Reset state
      repeat (3) tick();
      check("rst in_ready",      32'(in_ready),      32'd0);
      check("rst frame_ready",   32'(frame_ready),   32'd0);
      check("rst wr_count",      32'(wr_count),      32'd0);
      check("rst timeout_pulse", 32'(timeout_pulse), 32'd0);
      check("rst rd_data",       32'(rd_data),       32'd0);
      rst_n = 1'b1;
      tick();
      check("in_ready after rst", 32'(in_ready), 32'd1);

      // Fill frame A, then backpressure in WAIT_SWAP
      for (int i = 0; i < 183; i++) send_byte(8'(i));
      check("A in_ready low", 32'(in_ready), 32'd0);
      check("A wr_count",     32'(wr_count), 32'd183);
      in_byte = 8'hEE;
      repeat (100) tick();
      check("bp wr_count",   32'(wr_count), 32'd183);
      check("bp in_ready",   32'(in_ready), 32'd0);
      read_check("dark before swap", 8'd5, 8'h00);

      in_valid = 1'b0;
      pulse_sync();
      check("swap frame_ready", 32'(frame_ready), 32'd1);
      check("swap in_ready",    32'(in_ready),    32'd1);
      check("swap wr_count",    32'(wr_count),    32'd0);

      for (int i = 0; i < 9; i++) begin
         read_check($sformatf("A rd[%0d]", tbl_a[i].addr), tbl_a[i].addr, tbl_a[i].exp);
      end

      // Frame B: sync mid-fill and sync with the last byte are both ignored
      for (int i = 0; i < 50; i++) send_byte(8'(i + 100));
      in_valid = 1'b0;
      pulse_sync();
      check("mid sync wr_count",    32'(wr_count),    32'd50);
      check("mid sync frame_ready", 32'(frame_ready), 32'd1);
      read_check("front kept A", 8'd10, REORDER ? 8'd9 : 8'd10);
      for (int i = 50; i < 182; i++) send_byte(8'(i + 100));
      frame_sync = 1'b1;
      send_byte(8'(182 + 100));
      frame_sync = 1'b0;
      in_valid   = 1'b0;
      check("last+sync wr_count", 32'(wr_count), 32'd183);
      check("last+sync in_ready", 32'(in_ready), 32'd0);
      read_check("no swap with last", 8'd10, REORDER ? 8'd9 : 8'd10);

      // Read issued in the swap cycle still sees the old bank
      rd_addr    = 8'd10;
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      check("swap-cycle read old", 32'(rd_data), REORDER ? 32'd9 : 32'd10);
      tick();
      check("B read after swap", 32'(rd_data), REORDER ? 32'd109 : 32'd110);

      // Timeout after 10 bytes then idle
      for (int i = 0; i < 10; i++) send_byte(8'hAA);
      in_valid = 1'b0;
      check("pre-timeout wr_count", 32'(wr_count), 32'd10);
      k_hit  = 0;
      pulses = 0;
      for (int k = 1; k <= 50010; k++) begin
         tick();
         if (timeout_pulse) begin
            pulses++;
            if (k_hit == 0) k_hit = k;
         end
      end
      check("timeout cycle",    32'(k_hit),    32'd50000);
      check("timeout pulses",   32'(pulses),   32'd1);
      check("timeout wr_count", 32'(wr_count), 32'd0);
      check("timeout in_ready", 32'(in_ready), 32'd1);
      read_check("front after timeout", 8'd10, REORDER ? 8'd109 : 8'd110);

      // Full frame C after the discard
      for (int i = 0; i < 183; i++) send_byte(8'(i + 192));
      in_valid = 1'b0;
      check("C wr_count", 32'(wr_count), 32'd183);
      pulse_sync();
      read_check("C rd[182]", 8'd182, 8'd118);

      // Reset mid-fill
      for (int i = 0; i < 90; i++) send_byte(8'h55);
      check("pre-rst wr_count", 32'(wr_count), 32'd90);
      rst_n = 1'b0;
      #1;
      check("async rst in_ready",    32'(in_ready),    32'd0);
      check("async rst frame_ready", 32'(frame_ready), 32'd0);
      check("async rst wr_count",    32'(wr_count),    32'd0);
      check("async rst rd_data",     32'(rd_data),     32'd0);
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      read_check("dark after rst", 8'd5, 8'h00);
      for (int i = 0; i < 183; i++) send_byte(8'(i + 7));
      in_valid = 1'b0;
      read_check("dark before D swap", 8'd2, 8'h00);
      pulse_sync();
      read_check("D rd[2]", 8'd2, 8'd9);
      read_check("D rd[0]", 8'd0, REORDER ? 8'd8 : 8'd7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
